// File: rtl/cfg_pkg.sv
// Build-wide configuration shared by the stack engine blocks.
package cfg_pkg;
    localparam int PTR_N = 256;
endpackage

// File: rtl/stk_pkg.sv
// Shared types for the stack engine: entry pointer and free-list FSM states.
package stk_pkg;
    import cfg_pkg::*;

    localparam int PTR_W = $clog2(PTR_N);

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fl_state_t;
endpackage

// File: rtl/stk_freelist_ram.sv
// Ring storage for the free list: one synchronous write port, one asynchronous read port.
module stk_freelist_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/stk_freelist.sv
// Free-pointer FIFO for stack entry storage: self-initialising sweep, then one
// alloc and one dealloc per cycle with a sticky protocol-error flag.
module stk_freelist
    import stk_pkg::*;
#(
    parameter int  PTR_N = cfg_pkg::PTR_N,
    localparam int PTR_W = $clog2(PTR_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc,
    output logic [PTR_W-1:0] o_ptr_w,
    output logic             o_empty_r,
    output logic             o_busy,
    input  logic             i_dealloc_vld,
    input  logic [PTR_W-1:0] i_dealloc_ptr,
    output logic [PTR_W:0]   o_cnt_r,
    output logic             o_err_r
);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(PTR_N);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(PTR_N - 1);

    fl_state_t        state_r, state_nxt;
    logic [PTR_W-1:0] idx_r, rd_r, wr_r;
    logic [PTR_W:0]   cnt_r, cnt_nxt;
    logic             empty_r, err_r;

    logic             busy, sweep_last;
    logic             alloc_ok, dealloc_ok, err_hit;
    logic             ram_we;
    logic [PTR_W-1:0] ram_waddr, ram_wdata;

    assign busy       = (state_r == INIT);
    assign sweep_last = busy && (idx_r == IDX_LAST);

    assign alloc_ok   = !busy && i_alloc && !empty_r;
    assign dealloc_ok = !busy && i_dealloc_vld && (cnt_r != CNT_FULL);
    // Rejected requests only flag the error; they never touch ring or counters.
    assign err_hit    = (i_alloc && (busy || empty_r)) ||
                        (i_dealloc_vld && (busy || cnt_r == CNT_FULL));

    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        ram_we    = 1'b0;
        ram_waddr = wr_r;
        ram_wdata = i_dealloc_ptr;
        if (busy) begin
            ram_we    = 1'b1;
            ram_waddr = idx_r;
            ram_wdata = idx_r;
            if (sweep_last) begin
                state_nxt = RUN;
                cnt_nxt   = CNT_FULL;
            end
        end else begin
            ram_we = dealloc_ok;
            unique case ({alloc_ok, dealloc_ok})
                2'b10:   cnt_nxt = cnt_r - 1'b1;
                2'b01:   cnt_nxt = cnt_r + 1'b1;
                default: cnt_nxt = cnt_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= INIT;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= '0;
            rd_r    <= '0;
            wr_r    <= '0;
            cnt_r   <= '0;
            empty_r <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt;
            empty_r <= (cnt_nxt == '0);
            if (busy) begin
                idx_r <= idx_r + 1'b1;
            end
            if (alloc_ok) begin
                rd_r <= rd_r + 1'b1;
            end
            if (dealloc_ok) begin
                wr_r <= wr_r + 1'b1;
            end
            if (err_hit) begin
                err_r <= 1'b1;
            end
        end
    end

    stk_freelist_ram #(
        .DEPTH  (PTR_N),
        .ADDR_W (PTR_W),
        .DATA_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_r),
        .rdata (o_ptr_w)
    );

    assign o_busy    = busy;
    assign o_empty_r = empty_r;
    assign o_cnt_r   = cnt_r;
    assign o_err_r   = err_r;
endmodule

// File: tb/tb_stk_freelist.sv
// Self-checking bench for stk_freelist (PTR_N=8) against a queue-based free-list model.
module tb_stk_freelist;
    localparam int PTR_N = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_alloc = 1'b0;
    logic [PTR_W-1:0] o_ptr_w;
    logic             o_empty_r;
    logic             o_busy;
    logic             i_dealloc_vld = 1'b0;
    logic [PTR_W-1:0] i_dealloc_ptr = '0;
    logic [PTR_W:0]   o_cnt_r;
    logic             o_err_r;

    int errors = 0;
    int checks = 0;

    // Reference model: free pointers in hand-out order, cycles left in sweep, sticky error.
    logic [PTR_W-1:0] q[$];
    int               busy_left = PTR_N;
    bit               m_err = 1'b0;

    stk_freelist #(.PTR_N(PTR_N)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_alloc       (i_alloc),
        .o_ptr_w       (o_ptr_w),
        .o_empty_r     (o_empty_r),
        .o_busy        (o_busy),
        .i_dealloc_vld (i_dealloc_vld),
        .i_dealloc_ptr (i_dealloc_ptr),
        .o_cnt_r       (o_cnt_r),
        .o_err_r       (o_err_r)
    );

    always #5 clk = ~clk;

    // Entered and left at a negedge; inputs are held across one rising edge.
    task automatic step(input bit r, input bit a, input bit dv, input logic [PTR_W-1:0] dp);
        bit aok, dok;
        rst = r; i_alloc = a; i_dealloc_vld = dv; i_dealloc_ptr = dp;
        @(posedge clk);
        if (r) begin
            q.delete();
            busy_left = PTR_N;
            m_err = 1'b0;
        end else if (busy_left > 0) begin
            if (a || dv) m_err = 1'b1;
            busy_left--;
            if (busy_left == 0)
                for (int k = 0; k < PTR_N; k++) q.push_back(PTR_W'(k));
        end else begin
            aok = a && (q.size() != 0);
            dok = dv && (q.size() != PTR_N);
            if ((a && !aok) || (dv && !dok)) m_err = 1'b1;
            if (aok) void'(q.pop_front());
            if (dok) q.push_back(dp);
        end
        @(negedge clk);
        rst = 1'b0; i_alloc = 1'b0; i_dealloc_vld = 1'b0;
    endtask

    task automatic reset_and_sweep();
        step(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < PTR_N; k++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (o_busy !== 1'b1 || o_cnt_r !== 4'd0 || o_empty_r !== 1'b1 || o_err_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b cnt=%0d empty=%b err=%b, required busy=1 cnt=0 empty=1 err=0",
                     o_busy, o_cnt_r, o_empty_r, o_err_r);
        end
        for (int c = 0; c < PTR_N; c++) begin
            checks++;
            if (o_busy !== 1'b1) begin
                errors++;
                $display("FAIL sweep_busy cycle %0d: busy=%b, required 1", c, o_busy);
            end
            step(1'b0, 1'b0, 1'b0, '0);
        end
        checks++;
        if (o_busy !== 1'b0 || o_cnt_r !== 4'd8 || o_empty_r !== 1'b0 || o_ptr_w !== 3'd0) begin
            errors++;
            $display("FAIL after_sweep: busy=%b cnt=%0d empty=%b ptr=%0d, required busy=0 cnt=8 empty=0 ptr=0",
                     o_busy, o_cnt_r, o_empty_r, o_ptr_w);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < PTR_N; k++) begin
            checks++;
            if (o_ptr_w !== PTR_W'(k) || o_cnt_r !== 4'(PTR_N - k)) begin
                errors++;
                $display("FAIL b2b_alloc %0d: ptr=%0d cnt=%0d, required ptr=%0d cnt=%0d",
                         k, o_ptr_w, o_cnt_r, k, PTR_N - k);
            end
            step(1'b0, 1'b1, 1'b0, '0);
        end
        checks++;
        if (o_empty_r !== 1'b1 || o_cnt_r !== 4'd0 || o_err_r !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: empty=%b cnt=%0d err=%b, required empty=1 cnt=0 err=0",
                     o_empty_r, o_cnt_r, o_err_r);
        end
    endtask

    task automatic test_order();
        step(1'b0, 1'b0, 1'b1, 3'd5);
        checks++;
        if (o_cnt_r !== 4'd1 || o_empty_r !== 1'b0 || o_ptr_w !== 3'd5) begin
            errors++;
            $display("FAIL order_free5: cnt=%0d empty=%b ptr=%0d, required cnt=1 empty=0 ptr=5", o_cnt_r, o_empty_r, o_ptr_w);
        end
        step(1'b0, 1'b0, 1'b1, 3'd2);
        checks++;
        if (o_cnt_r !== 4'd2) begin
            errors++;
            $display("FAIL order_free2: cnt=%0d, required 2", o_cnt_r);
        end
        checks++;
        if (o_ptr_w !== 3'd5) begin
            errors++;
            $display("FAIL order_alloc1: ptr=%0d, required 5", o_ptr_w);
        end
        step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (o_ptr_w !== 3'd2 || o_cnt_r !== 4'd1) begin
            errors++;
            $display("FAIL order_alloc2: ptr=%0d cnt=%0d, required ptr=2 cnt=1", o_ptr_w, o_cnt_r);
        end
        step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (o_cnt_r !== 4'd0 || o_empty_r !== 1'b1 || o_err_r !== 1'b0) begin
            errors++;
            $display("FAIL order_drained: cnt=%0d empty=%b err=%b, required cnt=0 empty=1 err=0", o_cnt_r, o_empty_r, o_err_r);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < PTR_N - 1; k++) step(1'b0, 1'b0, 1'b1, PTR_W'((k * 3) % PTR_N));
        for (int c = 0; c < 20; c++) begin
            logic [PTR_W-1:0] head;
            head = q[0];
            checks++;
            if (o_ptr_w !== head || o_cnt_r !== 4'd7 || o_empty_r !== 1'b0) begin
                errors++;
                $display("FAIL simul cycle %0d: ptr=%0d cnt=%0d empty=%b, required ptr=%0d cnt=7 empty=0",
                         c, o_ptr_w, o_cnt_r, o_empty_r, head);
            end
            step(1'b0, 1'b1, 1'b1, head ^ 3'd1);
        end
        checks++;
        if (o_err_r !== 1'b0 || o_cnt_r !== 4'd7) begin
            errors++;
            $display("FAIL simul_end: err=%b cnt=%0d, required err=0 cnt=7", o_err_r, o_cnt_r);
        end
    endtask

    task automatic test_errors();
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (o_err_r !== 1'b1) begin
            errors++;
            $display("FAIL err_alloc_init: err=%b, required 1", o_err_r);
        end
        for (int k = 1; k < PTR_N; k++) step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (o_cnt_r !== 4'd8 || o_ptr_w !== 3'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL err_init_ignored: cnt=%0d ptr=%0d busy=%b, required cnt=8 ptr=0 busy=0", o_cnt_r, o_ptr_w, o_busy);
        end

        reset_and_sweep();
        step(1'b0, 1'b0, 1'b1, 3'd3);
        checks++;
        if (o_err_r !== 1'b1 || o_cnt_r !== 4'd8 || o_ptr_w !== 3'd0) begin
            errors++;
            $display("FAIL err_dealloc_full: err=%b cnt=%0d ptr=%0d, required err=1 cnt=8 ptr=0", o_err_r, o_cnt_r, o_ptr_w);
        end
        for (int k = 0; k < PTR_N; k++) begin
            checks++;
            if (o_ptr_w !== PTR_W'(k)) begin
                errors++;
                $display("FAIL err_full_order %0d: ptr=%0d, required %0d", k, o_ptr_w, k);
            end
            step(1'b0, 1'b1, 1'b0, '0);
        end

        reset_and_sweep();
        for (int k = 0; k < PTR_N; k++) step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (o_err_r !== 1'b0) begin
            errors++;
            $display("FAIL err_clean_drain: err=%b, required 0", o_err_r);
        end
        step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (o_err_r !== 1'b1 || o_cnt_r !== 4'd0 || o_empty_r !== 1'b1) begin
            errors++;
            $display("FAIL err_alloc_empty: err=%b cnt=%0d empty=%b, required err=1 cnt=0 empty=1", o_err_r, o_cnt_r, o_empty_r);
        end
    endtask

    task automatic test_mid_reset();
        reset_and_sweep();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (o_cnt_r !== 4'd5) begin
            errors++;
            $display("FAIL midrst_pre: cnt=%0d, required 5", o_cnt_r);
        end
        step(1'b1, 1'b1, 1'b1, 3'd6);
        checks++;
        if (o_busy !== 1'b1 || o_cnt_r !== 4'd0 || o_err_r !== 1'b0 || o_empty_r !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: busy=%b cnt=%0d err=%b empty=%b, required busy=1 cnt=0 err=0 empty=1",
                     o_busy, o_cnt_r, o_err_r, o_empty_r);
        end
        for (int k = 0; k < PTR_N; k++) step(1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_ptr_w !== PTR_W'(k) || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_seq %0d: ptr=%0d busy=%b, required ptr=%0d busy=0", k, o_ptr_w, o_busy, k);
            end
            step(1'b0, 1'b1, 1'b0, '0);
        end
    endtask

    task automatic test_random();
        reset_and_sweep();
        for (int c = 0; c < 400; c++) begin
            bit r, a, dv;
            checks++;
            if (o_busy !== (busy_left > 0) || o_cnt_r !== 4'(q.size()) ||
                o_empty_r !== (q.size() == 0) || o_err_r !== m_err) begin
                errors++;
                $display("FAIL rand_state cycle %0d: busy=%b cnt=%0d empty=%b err=%b, required busy=%b cnt=%0d empty=%b err=%b",
                         c, o_busy, o_cnt_r, o_empty_r, o_err_r, busy_left > 0, q.size(), q.size() == 0, m_err);
            end
            if (busy_left == 0 && q.size() != 0) begin
                checks++;
                if (o_ptr_w !== q[0]) begin
                    errors++;
                    $display("FAIL rand_head cycle %0d: ptr=%0d, required %0d", c, o_ptr_w, q[0]);
                end
            end
            r  = ($urandom_range(0, 149) == 0);
            a  = ($urandom_range(0, 2) != 0);
            dv = ($urandom_range(0, 2) != 0);
            step(r, a, dv, PTR_W'($urandom_range(0, PTR_N - 1)));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_order();
        test_simultaneous();
        test_errors();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
